// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand sequencer.
package calc_pkg;

    localparam int OPND_W = 8;

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        EXEC  = 2'b10,
        SHOW  = 2'b11
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_SHR = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchronizer, stability counter, and a one-cycle
// pulse on each accepted rising level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync_p0;
    logic             r_sync_p1;
    logic             r_level;
    logic             r_level_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
        end else begin
            r_sync_p0 <= btn_raw;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Any cycle where the synced level agrees with the accepted one restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync_p1 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_level <= ~r_level;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Operand capture FSM in front of the combinational math stage; holds the
// operands stable for the math stage and latches its result for display.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPND_W-1:0] sw,
    input  logic [1:0]        op_sel,
    input  logic              btn_enter,
    input  logic              btn_clear,
    input  logic [OPND_W-1:0] y_in,
    output logic [OPND_W-1:0] a_out,
    output logic [OPND_W-1:0] b_out,
    output logic [1:0]        op_out,
    output logic [OPND_W-1:0] result,
    output logic              result_valid,
    output logic [1:0]        state_out
);

    logic              w_enter_press;
    logic              w_clear_press;
    state_t            r_state;
    logic [OPND_W-1:0] r_a;
    logic [OPND_W-1:0] r_b;
    logic [1:0]        r_op;
    logic [OPND_W-1:0] r_result;
    logic              r_valid;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_enter),
        .press   (w_enter_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_clear),
        .press   (w_clear_press)
    );

    // Clear outranks Enter; result/valid persist through SHOW->GET_A->GET_B entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= GET_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else if (w_clear_press) begin
            r_state  <= GET_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                GET_A: begin
                    if (w_enter_press) begin
                        r_a     <= sw;
                        r_state <= GET_B;
                    end
                end
                GET_B: begin
                    if (w_enter_press) begin
                        r_b     <= sw;
                        r_op    <= op_sel;
                        r_valid <= 1'b0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= y_in;
                    r_valid  <= 1'b1;
                    r_state  <= SHOW;
                end
                SHOW: begin
                    if (w_enter_press) begin
                        r_state <= GET_A;
                    end
                end
                default: r_state <= GET_A;
            endcase
        end
    end

    assign a_out        = r_a;
    assign b_out        = r_b;
    assign op_out       = r_op;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign state_out    = r_state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Scoreboard bench for calc_operand_sequencer with a behavioural math stage.
module tb_calc_operand_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw;
    logic [1:0] op_sel;
    logic       btn_enter;
    logic       btn_clear;
    logic [7:0] y_in;
    logic [7:0] a_out;
    logic [7:0] b_out;
    logic [1:0] op_out;
    logic [7:0] result;
    logic       result_valid;
    logic [1:0] state_out;

    int n_chk;
    int n_err;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic       vld;
    } snap_t;

    snap_t exp_q[$];

    calc_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .op_sel       (op_sel),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .y_in         (y_in),
        .a_out        (a_out),
        .b_out        (b_out),
        .op_out       (op_out),
        .result       (result),
        .result_valid (result_valid),
        .state_out    (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the downstream math stage.
    always_comb begin
        y_in = 8'h00;
        case (op_out)
            2'b00: y_in = a_out + b_out;
            2'b01: y_in = a_out - b_out;
            2'b10: y_in = {a_out[6:0], 1'b0};
            default: y_in = {1'b0, a_out[7:1]};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] res, input logic vld);
        snap_t s;
        s.st = st; s.a = a; s.b = b; s.op = op; s.res = res; s.vld = vld;
        exp_q.push_back(s);
    endtask

    task automatic press_enter();
        btn_enter = 1'b1;
        repeat (12) @(posedge clk);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    // Monitor: every observed state transition pops and compares one expected snapshot.
    initial begin
        logic [1:0] prev;
        snap_t      act;
        snap_t      exp;
        prev = 2'b00;
        forever begin
            @(negedge clk);
            if (state_out !== prev) begin
                act = {state_out, a_out, b_out, op_out, result, result_valid};
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_transition: got state %b snap %h expected no transition",
                             state_out, act);
                end else begin
                    exp = exp_q.pop_front();
                    check($sformatf("transition_to_%b", exp.st), 32'(act), 32'(exp));
                end
                prev = state_out;
            end
        end
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b1;
        sw = 8'h00;
        op_sel = 2'b00;
        btn_enter = 1'b0;
        btn_clear = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("reset_state", 32'(state_out), 32'h0);
        check("reset_outputs", {a_out, b_out, op_out, result, result_valid}, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Full sequence: 0x0C - 0x05 = 0x07
        sw = 8'h0C;
        push(2'b01, 8'h0C, 8'h00, 2'b00, 8'h00, 1'b0);
        press_enter();
        sw = 8'h05; op_sel = 2'b01;
        push(2'b10, 8'h0C, 8'h05, 2'b01, 8'h00, 1'b0);
        push(2'b11, 8'h0C, 8'h05, 2'b01, 8'h07, 1'b1);
        press_enter();
        check("show_result", {state_out, result, result_valid}, {2'b11, 8'h07, 1'b1});

        // Result held through the next A/B entry until B is captured
        sw = 8'h20;
        push(2'b00, 8'h0C, 8'h05, 2'b01, 8'h07, 1'b1);
        press_enter();
        sw = 8'h30;
        push(2'b01, 8'h30, 8'h05, 2'b01, 8'h07, 1'b1);
        press_enter();
        check("result_hold", {result, result_valid}, {8'h07, 1'b1});

        // Bounce, then a steady press: one capture of B, 0x30<<1 = 0x60
        sw = 8'h10; op_sel = 2'b10;
        push(2'b10, 8'h30, 8'h10, 2'b10, 8'h07, 1'b0);
        push(2'b11, 8'h30, 8'h10, 2'b10, 8'h60, 1'b1);
        for (int i = 0; i < 10; i++) begin
            btn_enter = ~btn_enter;
            repeat (2) @(posedge clk);
        end
        check("bounce_no_advance", 32'(state_out), 32'h1);
        press_enter();

        // Held button in GET_A: single advance, A captured once
        push(2'b00, 8'h30, 8'h10, 2'b10, 8'h60, 1'b1);
        press_enter();
        sw = 8'h55;
        push(2'b01, 8'h55, 8'h10, 2'b10, 8'h60, 1'b1);
        btn_enter = 1'b1;
        repeat (25) @(posedge clk);
        sw = 8'h66;
        repeat (25) @(posedge clk);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        check("held_a_once", {state_out, a_out}, {2'b01, 8'h55});

        // Clear and Enter pressed together in GET_B: clear wins
        push(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (12) @(posedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (12) @(posedge clk);
        check("clear_priority", {state_out, a_out, b_out, op_out, result, result_valid}, 32'h0);

        // Async reset mid-operation with a debounce count in flight
        sw = 8'h11;
        push(2'b01, 8'h11, 8'h00, 2'b00, 8'h00, 1'b0);
        press_enter();
        push(2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0);
        btn_enter = 1'b1;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrun_reset", {state_out, a_out, b_out, op_out, result, result_valid}, 32'h0);
        btn_enter = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (15) @(posedge clk);
        check("post_reset_idle", 32'(state_out), 32'h0);

        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
